// File: rtl/diff_core_pkg.sv
// Shared core definitions: dispatcher state encoding and activation-group geometry.
package diff_core_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OFFER  = 2'd1,
        STREAM = 2'd2
    } disp_state_t;

    localparam int unsigned ACT_GROUP_SIZE = 6;
    localparam int unsigned ACT_WIDTH      = 8;

endpackage

// File: rtl/act_dispatch_col_first_set6.sv
// Priority encoder for a 6-bit mask: index of the most-significant set bit.
module first_set6 (
    input  logic [5:0] i_mask,
    output logic [2:0] o_idx,
    output logic       o_none
);

    always_comb begin
        o_idx  = '0;
        o_none = 1'b1;
        // Ascending scan so the highest set bit is the last one written.
        for (int unsigned i = 0; i < 6; i++) begin
            if (i_mask[i]) begin
                o_idx  = 3'(i);
                o_none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/act_dispatch_col.sv
// Per-column activation dispatcher: latches one group, offers its guard map,
// then streams only the guarded activations, one per consume pulse.
module act_dispatch_col #(
    parameter int unsigned ACT_WIDTH  = diff_core_pkg::ACT_WIDTH,
    parameter int unsigned GROUP_SIZE = diff_core_pkg::ACT_GROUP_SIZE,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            src_valid,
    output logic                            src_ready,
    input  logic [GROUP_SIZE*ACT_WIDTH-1:0] src_data,
    input  logic                            src_is_odd_row,
    input  logic                            src_end_of_row,
    input  logic                            cfg_bit_mode,
    input  logic                            cfg_kernal_mode,
    output logic                            valid_o,
    input  logic                            ready_i,
    output logic [GROUP_SIZE-1:0]           guard_map_o,
    output logic                            is_odd_row_o,
    output logic                            end_of_row_o,
    output logic                            kernal_mode_o,
    output logic                            bit_mode_o,
    output logic [ACT_WIDTH-1:0]            activation_o,
    input  logic                            activation_en_i,
    output logic [CNT_WIDTH-1:0]            group_cnt_o,
    output logic                            underflow_o
);

    import diff_core_pkg::*;

    disp_state_t                     r_state;
    disp_state_t                     w_state_nxt;
    logic [GROUP_SIZE*ACT_WIDTH-1:0] r_data;
    logic [GROUP_SIZE-1:0]           r_guard;
    logic [GROUP_SIZE-1:0]           r_rem;
    logic [GROUP_SIZE-1:0]           w_rem_nxt;
    logic [GROUP_SIZE-1:0]           w_src_guard;
    logic [GROUP_SIZE-1:0]           w_mask;
    logic [GROUP_SIZE-1:0]           w_onehot;
    logic [GROUP_SIZE-1:0]           w_mask_cleared;
    logic                            r_odd;
    logic                            r_eor;
    logic                            r_km;
    logic                            r_bm;
    logic [CNT_WIDTH-1:0]            r_cnt;
    logic                            r_underflow;
    logic [2:0]                      w_idx;
    logic                            w_none;
    logic                            w_accept;
    logic                            w_hs;
    logic                            w_underflow_evt;
    logic [ACT_WIDTH-1:0]            w_act;

    // Bit k of the guard map belongs to the element stored at src_data[k*W +: W].
    always_comb begin
        w_src_guard = '0;
        for (int unsigned i = 0; i < GROUP_SIZE; i++) begin
            w_src_guard[i] = |src_data[i*ACT_WIDTH +: ACT_WIDTH];
        end
        if (cfg_bit_mode) begin
            w_src_guard = '1;
        end
    end

    // OFFER previews the first guarded element, STREAM walks the remaining mask.
    assign w_mask         = (r_state == STREAM) ? r_rem : r_guard;
    assign w_onehot       = GROUP_SIZE'(1) << w_idx;
    assign w_mask_cleared = w_mask & ~w_onehot;

    first_set6 u_first_set6 (
        .i_mask (w_mask),
        .o_idx  (w_idx),
        .o_none (w_none)
    );

    always_comb begin
        w_act = '0;
        if (r_state != IDLE && !w_none) begin
            for (int unsigned i = 0; i < GROUP_SIZE; i++) begin
                if (32'(w_idx) == i) begin
                    w_act = r_data[i*ACT_WIDTH +: ACT_WIDTH];
                end
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_rem_nxt       = r_rem;
        w_accept        = 1'b0;
        w_hs            = 1'b0;
        w_underflow_evt = 1'b0;
        case (r_state)
            IDLE: begin
                w_underflow_evt = activation_en_i;
                if (src_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = OFFER;
                end
            end
            OFFER: begin
                if (ready_i) begin
                    w_hs = 1'b1;
                    if (r_guard == '0) begin
                        w_state_nxt = IDLE;
                    end else begin
                        // A consume in the handshake cycle already takes the first element.
                        w_rem_nxt   = activation_en_i ? w_mask_cleared : r_guard;
                        w_state_nxt = (w_rem_nxt == '0) ? IDLE : STREAM;
                    end
                end else begin
                    w_underflow_evt = activation_en_i;
                end
            end
            STREAM: begin
                if (activation_en_i) begin
                    w_rem_nxt = w_mask_cleared;
                    if (w_mask_cleared == '0) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_data      <= '0;
            r_guard     <= '0;
            r_rem       <= '0;
            r_odd       <= 1'b0;
            r_eor       <= 1'b0;
            r_km        <= 1'b0;
            r_bm        <= 1'b0;
            r_cnt       <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            if (w_accept) begin
                r_data  <= src_data;
                r_guard <= w_src_guard;
                r_odd   <= src_is_odd_row;
                r_eor   <= src_end_of_row;
                r_km    <= cfg_kernal_mode;
                r_bm    <= cfg_bit_mode;
            end
            if (w_hs) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_underflow_evt) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign src_ready     = (r_state == IDLE);
    assign valid_o       = (r_state == OFFER);
    assign guard_map_o   = r_guard;
    assign is_odd_row_o  = r_odd;
    assign end_of_row_o  = r_eor;
    assign kernal_mode_o = r_km;
    assign bit_mode_o    = r_bm;
    assign activation_o  = w_act;
    assign group_cnt_o   = r_cnt;
    assign underflow_o   = r_underflow;

endmodule

// File: doc/act_dispatch_col.md
# act_dispatch_col

Per-column activation dispatcher that drives one PE-matrix column. It accepts 6-element activation groups from the activation buffer and computes the 6-bit non-zero guard map for each group. It offers that group descriptor to the column over valid/ready, then streams only the non-zero activations, one per `activation_en_i` pulse. One instance is built per column (`CONF_PE_COL` total) inside the core, sitting between the activation buffer and the PE matrix.

## Interface
Parameters:
- `ACT_WIDTH`, 8, activation width in bits.
- `GROUP_SIZE`, 6, elements per group; equals the guard-map width.
- `CNT_WIDTH`, 16, width of the group counter.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `src_valid`  in  1  activation buffer presents a group.
- `src_ready`  out  1  dispatcher accepts a group.
- `src_data`  in  GROUP_SIZE*ACT_WIDTH  group data; `[47:40]` is element 0 and `[7:0]` is element 5.
- `src_is_odd_row`, `src_end_of_row`  in  1 each  row tags, latched with the group.
- `cfg_bit_mode`, `cfg_kernal_mode`  in  1 each  mode inputs, latched with the group.
- `valid_o`  out  1  descriptor offered to the column.
- `ready_i`  in  1  column ready.
- `guard_map_o`  out  6  non-zero mask; bit5 is element 0.
- `is_odd_row_o`, `end_of_row_o`, `kernal_mode_o`, `bit_mode_o`  out  1 each  latched tags.
- `activation_o`  out  ACT_WIDTH  current non-zero activation.
- `activation_en_i`  in  1  column consumes `activation_o` this cycle.
- `group_cnt_o`  out  CNT_WIDTH  number of completed descriptor handshakes, wrapping.
- `underflow_o`  out  1  sticky error flag.

## Operation
- States: `IDLE`, `OFFER`, `STREAM`.
- `IDLE`:
  - `src_ready=1`.
  - On `src_valid`, latch data and tags, then go to `OFFER`.
  - `guard[5-k] = (elem k != 0)`.
  - If latched `bit_mode=1`, force guard to `6'b111111` (dense).
- `OFFER`:
  - `valid_o=1`.
  - Descriptor outputs reflect the latched values and are held stable until the handshake.
  - Handshake is `valid_o && ready_i`, which increments `group_cnt_o`.
  - Guard `0` at handshake → `IDLE`; no activation is streamed.
  - Otherwise the remaining mask `rem` = guard and the state becomes `STREAM`. If `activation_en_i=1` in the same cycle, that cycle consumes the first element.
- `STREAM`:
  - `activation_o` = element at the most-significant set bit of `rem` (lowest element index).
  - Each `activation_en_i=1` cycle clears that bit.
  - When `rem` becomes 0 → `IDLE`.
- In `OFFER`, `activation_o` already shows the first non-zero element of the guard. In `IDLE`, `activation_o=0`.
- `activation_en_i=1` in `IDLE`, or in `OFFER` without a handshake, sets `underflow_o`. It is cleared only by reset.
- `src_ready=0` in `OFFER` and `STREAM`. Exactly one group is held at a time.

## Timing
- Reset values (synchronous `rst_n=0`, at any state):
  - State → `IDLE`.
  - `src_ready=1`.
  - `valid_o=0`, `guard_map_o=0`, all tag outputs 0, `activation_o=0`.
  - `group_cnt_o=0`, `underflow_o=0`.
- Reset mid-`STREAM` discards the held group.
- Source accept → `valid_o` high the next cycle (1-cycle latency).
- A group with k non-zeros, with `ready_i` and `activation_en_i` held high, occupies the dispatcher for:
  - k≥1: 1 (`IDLE`) + k cycles before the next `src_ready`.
  - guard 0: 2 cycles.
- `activation_o` changes only on the edge after a consuming cycle, or on a new latch.
- `group_cnt_o` wraps from `2^CNT_WIDTH-1` to 0.
- `ready_i` is ignored outside `OFFER`. `src_valid` is ignored while `src_ready=0`.

## Structure
- Shared package `diff_core_pkg`:
  - Add `disp_state_t` with the states `IDLE`, `OFFER`, `STREAM`.
  - Add the constants `ACT_GROUP_SIZE=6` and `ACT_WIDTH=8`.
- Sub-module `first_set6`: a combinational priority encoder for the 6-bit mask. It returns the index of the MSB set bit and a `none` flag. It drives both the `activation_o` mux and the bit clear of `rem`.

## Test plan
- Group `{05,00,00,07,00,09}` (element0 first), `ready_i=1`, `activation_en_i=1` → `guard_map_o=6'b100101`; `activation_o` sequence `05,07,09`; `src_ready` back after 3 stream cycles; `group_cnt_o=1`.
- All-zero group → `guard_map_o=0`, one `valid_o` cycle, no activations, `IDLE` next cycle, `group_cnt_o` increments.
- `cfg_bit_mode=1`, group `{00,01,00,02,00,03}` → `guard_map_o=6'b111111`; six activations `00,01,00,02,00,03`.
- `ready_i=0` for 4 cycles in `OFFER` → `valid_o` and descriptor held stable; `activation_o=first non-zero`; no consumption.
- `activation_en_i` toggling 1,0,1,0,1 on guard `6'b110000` → elements advance only on the high cycles.
- `activation_en_i=1` in `IDLE` → `underflow_o=1`, held until reset. Assert `rst_n=0` mid-`STREAM` → all outputs return to their reset values the next cycle.
